mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one sequential multiplier (mult) between N_REQ requesters.
//  Arbitrates, latches the winner's operands and pulses the multiplier's start_i.
//  Tracks its busy_o and returns y_bo to the winner with a done pulse.
//  Sits between client FSMs and the single mult instance; the instance has no other driver.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  WIDTH     8   operand width; result is 2*WIDTH
//  BUSY_WAIT 4   max cycles after start for mult busy_o to rise before error
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          asynchronous reset, active-low
//  req_i        in   N_REQ      per-requester request level
//  a_i          in   N_REQ*WIDTH operands A, requester k at [k*WIDTH +: WIDTH]
//  b_i          in   N_REQ*WIDTH operands B, same packing
//  gnt_o        out  N_REQ      one-hot, 1-cycle pulse: operands captured
//  done_o       out  N_REQ      one-hot, 1-cycle pulse: result/err valid for owner
//  y_o          out  2*WIDTH    result, held until next done
//  err_o        out  1          valid with done_o; 1 = mult never went busy
//  arb_busy_o   out  1          high whenever state != IDLE
//  mult_start_o out  1          to mult start_i
//  mult_a_o     out  WIDTH      to mult a_bi, stable from START until DONE
//  mult_b_o     out  WIDTH      to mult b_bi, stable from START until DONE
//  mult_busy_i  in   1          from mult busy_o
//  mult_y_i     in   2*WIDTH    from mult y_bo
// BEHAVIOUR
//  Reset (rst_i=0, any time, async): state=IDLE, all outputs 0, wait cnt=0, priority ptr=0.
//  Mid-operation reset abandons the op; no done issued. The mult is reset by the system reset.
//  States:
//  - IDLE: if any req_i and mult_busy_i=0 -> latch winner idx, a, b -> START.
//    If mult_busy_i=1 (stale/foreign op), no grant; stay in IDLE.
//  - START (1 cycle): gnt_o[idx]=1, mult_start_o=1 -> WAIT_BUSY, cnt=0.
//  - WAIT_BUSY: mult_busy_i=1 -> RUN.
//    Else cnt++; when cnt==BUSY_WAIT-1 -> DONE with err=1, y_o=0.
//  - RUN: mult_busy_i=0 -> y_o<=mult_y_i, err=0 -> DONE.
//  - DONE (1 cycle): done_o[idx]=1, err_o valid -> IDLE; priority ptr updated here.
//  Latency req->done = 1 (IDLE sample) + 1 + busy-rise cycles + mult run + 1.
//  Min 3 cycles of arbiter overhead. Back-to-back ops: one IDLE cycle between DONE and next START.
//  Requester rules:
//  - Hold req_i and operands until gnt_o; may drop req on/after gnt.
//  - req_i still high in IDLE after own done = new request.
//  - req dropped before grant = withdrawn; never granted.
//  req_i changes during START..DONE are ignored; only IDLE samples.
//  y_o, err_o hold last values between dones; gnt_o/done_o never overlap in one cycle.
//  mult_a_o/b_o outputs are registers, not a combinational mux of a_i/b_i.
// CONFIGURATION
//  MULT_ARB_RR_EN defined: round-robin arbitration.
//  - Search starts at ptr; on DONE, ptr <= idx+1 (wraps N_REQ-1 -> 0).
//  - A continuously requesting client waits at most N_REQ-1 ops.
//  Undefined: fixed priority, lowest index wins; ptr unused (stays 0).
// TESTING
//  T1 reset: rst_i=0 mid-RUN -> all outputs 0 same cycle; after release, IDLE, no done.
//  T2 single op: req_i=0001, a=8, b=8 -> gnt_o=0001 once, then done_o=0001, y_o=64, err_o=0.
//  T3 contention, RR_EN: req_i=1111 held, a_k=k+1, b_k=3 -> done order 0,1,2,3,0.
//     Results 3,6,9,12,3.
//  T4 contention, no RR_EN: req_i=0110 held -> requester 1 served repeatedly, never 2.
//  T5 timeout: mult_busy_i tied 0, req_i=0100 -> done_o=0100, err_o=1, y_o=0.
//     done occurs BUSY_WAIT cycles after start.
//  T6 stale busy: mult_busy_i=1 at request -> no gnt until it falls, then normal op.
//     Also: withdraw req before grant -> no gnt.

Source files
------------

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - arbitrates N_REQ clients onto one sequential multiplier
// Optional MULT_ARB_RR_EN selects round-robin; default is fixed priority (lowest index wins).
module mult_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int BUSY_WAIT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] a_i,
  input  logic [N_REQ*WIDTH-1:0] b_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [2*WIDTH-1:0]     y_o,
  output logic                   err_o,
  output logic                   arb_busy_o,
  output logic                   mult_start_o,
  output logic [WIDTH-1:0]       mult_a_o,
  output logic [WIDTH-1:0]       mult_b_o,
  input  logic                   mult_busy_i,
  input  logic [2*WIDTH-1:0]     mult_y_i
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int CW   = $clog2(BUSY_WAIT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_nxt;
  logic [IDXW-1:0]     idx_q, idx_nxt;
  logic [CW-1:0]       cnt_q, cnt_nxt, cnt_inc;
  logic [2*WIDTH-1:0]  y_nxt;
  logic                err_nxt;
  logic [WIDTH-1:0]    a_nxt, b_nxt;
  logic                win_vld;
  logic [IDXW-1:0]     win_idx;

`ifdef MULT_ARB_RR_EN
  logic [IDXW-1:0]     ptr_q, ptr_nxt;
`endif

  // Winner selection; only consulted while IDLE.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef MULT_ARB_RR_EN
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
`else
      j = i;
`endif
      if (!win_vld && req_i[IDXW'(j)]) begin
        win_vld = 1'b1;
        win_idx = IDXW'(j);
      end
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    y_nxt     = y_o;
    err_nxt   = err_o;
    a_nxt     = mult_a_o;
    b_nxt     = mult_b_o;
`ifdef MULT_ARB_RR_EN
    ptr_nxt   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // A busy multiplier here belongs to an abandoned op; wait it out.
        if (win_vld && !mult_busy_i) begin
          idx_nxt   = win_idx;
          a_nxt     = a_i[win_idx*WIDTH +: WIDTH];
          b_nxt     = b_i[win_idx*WIDTH +: WIDTH];
          state_nxt = START;
        end
      end
      START: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (mult_busy_i) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CW'(BUSY_WAIT - 1)) begin
            y_nxt     = '0;
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (!mult_busy_i) begin
          y_nxt     = mult_y_i;
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
`ifdef MULT_ARB_RR_EN
        ptr_nxt = (idx_q == IDXW'(N_REQ - 1)) ? '0 : idx_q + IDXW'(1);
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      y_o      <= '0;
      err_o    <= 1'b0;
      mult_a_o <= '0;
      mult_b_o <= '0;
`ifdef MULT_ARB_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_nxt;
      idx_q    <= idx_nxt;
      cnt_q    <= cnt_nxt;
      y_o      <= y_nxt;
      err_o    <= err_nxt;
      mult_a_o <= a_nxt;
      mult_b_o <= b_nxt;
`ifdef MULT_ARB_RR_EN
      ptr_q    <= ptr_nxt;
`endif
    end
  end

  // Pulses decode from state so an async reset clears them in the same cycle.
  assign gnt_o        = (state_q == START) ? (N_REQ'(1) << idx_q) : '0;
  assign done_o       = (state_q == DONE)  ? (N_REQ'(1) << idx_q) : '0;
  assign mult_start_o = (state_q == START);
  assign arb_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard bench for mult_arbiter with a behavioural multiplier
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BW = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] a_i, b_i;
  logic [N-1:0]   gnt_o, done_o;
  logic [2*W-1:0] y_o;
  logic           err_o, arb_busy_o, mult_start_o;
  logic [W-1:0]   mult_a_o, mult_b_o;
  logic           mult_busy_i;
  logic [2*W-1:0] mult_y_i;

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .BUSY_WAIT(BW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .gnt_o(gnt_o), .done_o(done_o), .y_o(y_o), .err_o(err_o),
    .arb_busy_o(arb_busy_o), .mult_start_o(mult_start_o),
    .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
    .mult_busy_i(mult_busy_i), .mult_y_i(mult_y_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural multiplier: busy rises the cycle after start, four busy cycles.
  logic           m_busy;
  logic [2:0]     m_cnt;
  logic [2*W-1:0] m_y;
  logic           tie_low, force_busy;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_y    <= '0;
    end else if (mult_start_o) begin
      m_busy <= 1'b1;
      m_cnt  <= 3'd3;
      m_y    <= {8'b0, mult_a_o} * {8'b0, mult_b_o};
    end else if (m_busy) begin
      if (m_cnt == 3'd0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 3'd1;
    end
  end

  assign mult_busy_i = force_busy ? 1'b1 : (tie_low ? 1'b0 : m_busy);
  assign mult_y_i    = m_y;

  typedef struct {
    int             idx;
    logic [2*W-1:0] y;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   done_cnt    = 0;
  int   gnt_cnt[N]  = '{default: 0};
  int   gnt_cyc     = 0;
  int   done_cyc    = 0;
  logic [N-1:0] last_gnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (gnt_o != '0) begin
        gnt_cyc  = cyc;
        last_gnt = gnt_o;
        for (int k = 0; k < N; k++) if (gnt_o[k]) gnt_cnt[k]++;
      end
      if (done_o != '0) begin
        exp_t e;
        done_cnt++;
        done_cyc = cyc;
        chk("gnt_done_overlap", {28'b0, gnt_o}, 32'h0);
        if (sb.size() == 0) begin
          chk("unexpected_done", {28'b0, done_o}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("done_idx", {28'b0, done_o}, 32'(1) << e.idx);
          chk("y", {16'b0, y_o}, {16'b0, e.y});
          chk("err", {31'b0, err_o}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic push(input int idx, input int y, input logic err);
    exp_t e;
    e.idx = idx;
    e.y   = 16'(y);
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_ops(input int k, input int a, input int b);
    a_i[k*W +: W] = 8'(a);
    b_i[k*W +: W] = 8'(b);
  endtask

  task automatic wait_dones(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk(tag, {31'b0, done_cnt >= target}, 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},   {28'b0, gnt_o}, 32'h0);
    chk({tag, "_done"},  {28'b0, done_o}, 32'h0);
    chk({tag, "_y"},     {16'b0, y_o}, 32'h0);
    chk({tag, "_err"},   {31'b0, err_o}, 32'h0);
    chk({tag, "_busy"},  {31'b0, arb_busy_o}, 32'h0);
    chk({tag, "_start"}, {31'b0, mult_start_o}, 32'h0);
    chk({tag, "_ma"},    {24'b0, mult_a_o}, 32'h0);
    chk({tag, "_mb"},    {24'b0, mult_b_o}, 32'h0);
  endtask

  initial begin
    int g0, d0, n;
    rst_i = 1'b0; req_i = '0; a_i = '0; b_i = '0;
    tie_low = 1'b0; force_busy = 1'b0;
    idle(3);
    check_zero("reset");
    rst_i = 1'b1;
    idle(2);

    // Contention on all four requesters.
    for (int k = 0; k < N; k++) set_ops(k, k + 1, 3);
`ifdef MULT_ARB_RR_EN
    push(0, 3, 0); push(1, 6, 0); push(2, 9, 0); push(3, 12, 0); push(0, 3, 0);
`else
    for (int k = 0; k < 5; k++) push(0, 3, 0);
`endif
    d0 = done_cnt;
    req_i = 4'b1111;
    wait_dones(d0 + 5, 200, "t3_complete");
    req_i = '0;
    idle(3);

    // Requesters 1 and 2 contend; ptr sits at 1 after the previous run.
    set_ops(1, 4, 5); set_ops(2, 6, 7);
`ifdef MULT_ARB_RR_EN
    push(1, 20, 0); push(2, 42, 0); push(1, 20, 0);
`else
    push(1, 20, 0); push(1, 20, 0); push(1, 20, 0);
`endif
    g0 = gnt_cnt[2];
    d0 = done_cnt;
    req_i = 4'b0110;
    wait_dones(d0 + 3, 150, "t4_complete");
    req_i = '0;
`ifndef MULT_ARB_RR_EN
    chk("t4_no_gnt2", 32'(gnt_cnt[2] - g0), 32'h0);
`endif
    idle(3);

    // Single op with latency check.
    set_ops(0, 8, 8);
    push(0, 64, 0);
    g0 = gnt_cnt[0];
    d0 = done_cnt;
    req_i = 4'b0001;
    wait_dones(d0 + 1, 40, "t2_complete");
    req_i = '0;
    chk("t2_gnt_once", 32'(gnt_cnt[0] - g0), 32'h1);
    chk("t2_gnt_val", {28'b0, last_gnt}, 32'h1);
    chk("t2_latency", 32'(done_cyc - gnt_cyc), 32'd6);
    idle(3);

    // Multiplier never goes busy.
    tie_low = 1'b1;
    set_ops(2, 7, 9);
    push(2, 0, 1);
    d0 = done_cnt;
    req_i = 4'b0100;
    wait_dones(d0 + 1, 40, "t5_complete");
    req_i = '0;
    chk("t5_timeout_cycles", 32'(done_cyc - gnt_cyc), 32'(BW));
    idle(6);
    tie_low = 1'b0;
    idle(2);

    // Stale busy blocks grants; requester 3 withdraws before being served.
    force_busy = 1'b1;
    set_ops(1, 2, 10); set_ops(3, 9, 9);
    g0 = gnt_cnt[1] + gnt_cnt[3];
    req_i = 4'b1010;
    idle(6);
    chk("t6_no_gnt_busy", 32'(gnt_cnt[1] + gnt_cnt[3] - g0), 32'h0);
    chk("t6_arb_idle", {31'b0, arb_busy_o}, 32'h0);
    req_i = 4'b0010;
    g0 = gnt_cnt[3];
    push(1, 20, 0);
    d0 = done_cnt;
    idle(1);
    force_busy = 1'b0;
    wait_dones(d0 + 1, 40, "t6_complete");
    req_i = '0;
    chk("t6_withdrawn", 32'(gnt_cnt[3] - g0), 32'h0);
    idle(3);

    // Reset in the middle of RUN abandons the op.
    set_ops(0, 5, 5);
    g0 = gnt_cnt[0];
    req_i = 4'b0001;
    n = 0;
    while (gnt_cnt[0] == g0 && n < 20) begin @(negedge clk_i); n++; end
    chk("t1_got_gnt", {31'b0, gnt_cnt[0] != g0}, 32'h1);
    req_i = '0;
    idle(2);
    chk("t1_in_run", {31'b0, arb_busy_o & mult_busy_i}, 32'h1);
    d0 = done_cnt;
    rst_i = 1'b0;
    #1;
    check_zero("t1_reset");
    idle(2);
    rst_i = 1'b1;
    idle(12);
    chk("t1_no_done", 32'(done_cnt - d0), 32'h0);
    chk("t1_idle", {31'b0, arb_busy_o}, 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
